// File: rtl/step_gen_pkg.sv
// Shared motion definitions for the step pulse generator.
// FSM encoding, default timing and the period clamp.
package step_gen_pkg;

    localparam int unsigned PULSE_W_DEF   = 100;
    localparam int unsigned DIR_SETUP_DEF = 50;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_HI    = 2'd2;
    localparam logic [1:0] ST_LO    = 2'd3;

    // A period shorter than the high time plus one low cycle is stretched.
    function automatic logic [31:0] eff_period(
        input logic [31:0] period,
        input logic [31:0] min_per
    );
        return (period < min_per) ? min_per : period;
    endfunction

endpackage

// File: rtl/step_gen_if.sv
// Move command handshake between a motion planner and step_gen.
// The planner holds cmd_valid and the fields until cmd_ready.
interface step_gen_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_steps;
    logic [31:0] cmd_period;
    logic        cmd_dir;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_period,
        output cmd_dir,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_period,
        input  cmd_dir,
        output cmd_ready
    );

endinterface

// File: rtl/step_gen.sv
// Step/dir pulse generator for a stepper driver.
// One down-counter times dir setup, step high and step low.
module step_gen
    import step_gen_pkg::*;
#(
    parameter int unsigned PULSE_W   = PULSE_W_DEF,
    parameter int unsigned DIR_SETUP = DIR_SETUP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    step_gen_if.slave   cmd,
    input  logic        abort,
    output logic        step,
    output logic        dir,
    output logic        busy,
    output logic        done,
    output logic [31:0] position,
    output logic [31:0] steps_left
);

    localparam logic [31:0] SU_LOAD = 32'(DIR_SETUP - 1);
    localparam logic [31:0] HI_LOAD = 32'(PULSE_W - 1);
    localparam logic [31:0] MIN_PER = 32'(PULSE_W + 1);

    logic [1:0]  state;
    logic [31:0] cnt;
    logic [31:0] per_q;
    logic        abort_q;
    logic [31:0] pos_nxt;
    logic [31:0] lo_load;

    assign cmd.cmd_ready = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign pos_nxt       = dir ? position + 32'd1
                               : position - 32'd1;
    assign lo_load       = per_q - MIN_PER;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            per_q      <= '0;
            abort_q    <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            done       <= 1'b0;
            position   <= '0;
            steps_left <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    abort_q <= 1'b0;
                    if (cmd.cmd_valid) begin
                        if (cmd.cmd_steps == '0) begin
                            done <= 1'b1;
                        end else begin
                            dir        <= cmd.cmd_dir;
                            steps_left <= cmd.cmd_steps;
                            per_q      <= eff_period(
                                cmd.cmd_period, MIN_PER);
                            cnt        <= SU_LOAD;
                            state      <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (abort) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        step       <= 1'b1;
                        steps_left <= steps_left - 32'd1;
                        position   <= pos_nxt;
                        cnt        <= HI_LOAD;
                        state      <= ST_HI;
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_HI: begin
                    // An abort is remembered so the pulse keeps full width.
                    if (abort) abort_q <= 1'b1;
                    if (cnt == '0) begin
                        step <= 1'b0;
                        if (abort || abort_q) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= lo_load;
                            state <= ST_LO;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                ST_LO: begin
                    if (abort) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (cnt == '0) begin
                        if (steps_left != '0) begin
                            step       <= 1'b1;
                            steps_left <= steps_left - 32'd1;
                            position   <= pos_nxt;
                            cnt        <= HI_LOAD;
                            state      <= ST_HI;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 32'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_gen.sv
// Scoreboard bench for step_gen with PULSE_W=4, DIR_SETUP=2.
// Offsets are counted in clk edges from the acceptance edge.
module tb_step_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        abort = 1'b0;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] position;
    logic [31:0] steps_left;

    step_gen_if bus ();

    step_gen #(
        .PULSE_W   (4),
        .DIR_SETUP (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (bus),
        .abort      (abort),
        .step       (step),
        .dir        (dir),
        .busy       (busy),
        .done       (done),
        .position   (position),
        .steps_left (steps_left)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    int exp_rise[$];
    int exp_width[$];
    int got_rise[$];
    int got_width[$];
    int done_off;
    bit busy_seen;
    logic [31:0] exp_pos;

    task automatic send_cmd(
        input logic [31:0] steps,
        input logic [31:0] period,
        input logic        d,
        input logic        ab
    );
        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_steps  = steps;
        bus.cmd_period = period;
        bus.cmd_dir    = d;
        abort          = ab;
        @(posedge clk);
        #1;
        bus.cmd_valid  = 1'b0;
        abort          = 1'b0;
        bus.cmd_steps  = $urandom;
        bus.cmd_period = $urandom_range(1, 3);
        bus.cmd_dir    = ~d;
    endtask

    // Collects step rises, pulse widths and the done offset.
    task automatic watch(input int limit, input int abort_at);
        int   k = 0;
        int   w = 0;
        logic prev = 1'b0;
        got_rise.delete();
        got_width.delete();
        done_off  = -1;
        busy_seen = 1'b0;
        while (1) begin
            if (busy) busy_seen = 1'b1;
            if (step) begin
                if (!prev) got_rise.push_back(k);
                w++;
            end else if (prev) begin
                got_width.push_back(w);
                w = 0;
            end
            prev = step;
            if (done) begin
                done_off = k;
                break;
            end
            abort = (k == abort_at);
            if (k >= limit) break;
            @(posedge clk);
            #1;
            k++;
        end
        abort = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_chk += 6;
        if ({step, dir, busy, done} !== 4'b0000)
            $display("FAIL rst_flags got %b want 0000",
                     {step, dir, busy, done});
        else n_pass++;
        if (position !== 32'd0)
            $display("FAIL rst_pos got %h want 0", position);
        else n_pass++;
        if (steps_left !== 32'd0)
            $display("FAIL rst_left got %h want 0", steps_left);
        else n_pass++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL rst_ready got %b want 1", bus.cmd_ready);
        else n_pass++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        if (bus.cmd_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL rel_ready got %b/%b want 1/0",
                     bus.cmd_ready, busy);
        else n_pass++;
        if (done !== 1'b0)
            $display("FAIL rel_done got %b want 0", done);
        else n_pass++;
        exp_pos = 32'd0;
    endtask

    task automatic test_basic;
        int g;
        exp_rise  = '{2, 12, 22};
        exp_width = '{4, 4, 4};
        exp_pos   = exp_pos + 32'd3;
        send_cmd(32'd3, 32'd10, 1'b1, 1'b0);
        watch(200, -1);
        while (exp_rise.size() > 0) begin
            int e = exp_rise.pop_front();
            g = got_rise.size() > 0 ? got_rise.pop_front() : -1;
            n_chk++;
            if (g !== e)
                $display("FAIL basic_rise got %0d want %0d", g, e);
            else n_pass++;
        end
        while (exp_width.size() > 0) begin
            int e = exp_width.pop_front();
            g = got_width.size() > 0 ? got_width.pop_front() : -1;
            n_chk++;
            if (g !== e)
                $display("FAIL basic_width got %0d want %0d", g, e);
            else n_pass++;
        end
        n_chk += 4;
        if (done_off !== 32)
            $display("FAIL basic_done got %0d want 32", done_off);
        else n_pass++;
        if (position !== exp_pos || dir !== 1'b1)
            $display("FAIL basic_pos got %h/%b want %h/1",
                     position, dir, exp_pos);
        else n_pass++;
        if (steps_left !== 32'd0)
            $display("FAIL basic_left got %0d want 0", steps_left);
        else n_pass++;
        @(posedge clk);
        #1;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_done_len got %b/%b want 0/0",
                     done, busy);
        else n_pass++;
    endtask

    task automatic test_clamp;
        int g;
        exp_rise  = '{2, 7};
        exp_width = '{4, 4};
        exp_pos   = exp_pos - 32'd2;
        send_cmd(32'd2, 32'd3, 1'b0, 1'b1);
        watch(200, -1);
        while (exp_rise.size() > 0) begin
            int e = exp_rise.pop_front();
            g = got_rise.size() > 0 ? got_rise.pop_front() : -1;
            n_chk++;
            if (g !== e)
                $display("FAIL clamp_rise got %0d want %0d", g, e);
            else n_pass++;
        end
        while (exp_width.size() > 0) begin
            int e = exp_width.pop_front();
            g = got_width.size() > 0 ? got_width.pop_front() : -1;
            n_chk++;
            if (g !== e)
                $display("FAIL clamp_width got %0d want %0d", g, e);
            else n_pass++;
        end
        n_chk += 2;
        if (done_off !== 12)
            $display("FAIL clamp_done got %0d want 12", done_off);
        else n_pass++;
        if (position !== exp_pos || dir !== 1'b0)
            $display("FAIL clamp_pos got %h/%b want %h/0",
                     position, dir, exp_pos);
        else n_pass++;
    endtask

    task automatic test_zero;
        repeat (3) begin
            @(negedge clk);
            abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_abort got %b/%b want 0/0", busy, done);
        else n_pass++;
        send_cmd(32'd0, 32'd10, 1'b1, 1'b0);
        watch(20, -1);
        n_chk += 3;
        if (done_off !== 0)
            $display("FAIL zero_done got %0d want 0", done_off);
        else n_pass++;
        if (got_rise.size() !== 0 || busy_seen !== 1'b0)
            $display("FAIL zero_idle got %0d/%b want 0/0",
                     got_rise.size(), busy_seen);
        else n_pass++;
        if (dir !== 1'b0 || position !== exp_pos)
            $display("FAIL zero_keep got %b/%h want 0/%h",
                     dir, position, exp_pos);
        else n_pass++;
    endtask

    task automatic test_abort;
        exp_pos = exp_pos + 32'd2;
        send_cmd(32'd10, 32'd10, 1'b1, 1'b0);
        watch(200, 13);
        n_chk += 4;
        if (done_off !== 16)
            $display("FAIL abort_hi_done got %0d want 16", done_off);
        else n_pass++;
        if (got_width.size() !== 2 || got_width[1] !== 4)
            $display("FAIL abort_hi_width got %0d pulses want 2x4",
                     got_width.size());
        else n_pass++;
        if (steps_left !== 32'd8)
            $display("FAIL abort_hi_left got %0d want 8", steps_left);
        else n_pass++;
        if (position !== exp_pos)
            $display("FAIL abort_hi_pos got %h want %h",
                     position, exp_pos);
        else n_pass++;
        send_cmd(32'd4, 32'd10, 1'b0, 1'b0);
        watch(50, 0);
        n_chk += 2;
        if (done_off !== 1 || got_rise.size() !== 0)
            $display("FAIL abort_su got %0d/%0d want 1/0",
                     done_off, got_rise.size());
        else n_pass++;
        if (steps_left !== 32'd4 || position !== exp_pos)
            $display("FAIL abort_su_left got %0d/%h want 4/%h",
                     steps_left, position, exp_pos);
        else n_pass++;
    endtask

    task automatic test_wrap;
        @(negedge clk);
        force dut.position = 32'h7FFF_FFFF;
        @(posedge clk);
        #1;
        release dut.position;
        exp_pos = 32'h7FFF_FFFF;
        @(negedge clk);
        n_chk++;
        if (position !== exp_pos)
            $display("FAIL wrap_preset got %h want %h",
                     position, exp_pos);
        else n_pass++;
        exp_pos = exp_pos + 32'd1;
        send_cmd(32'd1, 32'd5, 1'b1, 1'b0);
        watch(100, -1);
        n_chk += 2;
        if (done_off !== 7)
            $display("FAIL wrap_done got %0d want 7", done_off);
        else n_pass++;
        if (position !== 32'h8000_0000)
            $display("FAIL wrap_pos got %h want 80000000", position);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        int g;
        send_cmd(32'd5, 32'd10, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        n_chk += 3;
        if (step !== 1'b1)
            $display("FAIL mid_pre got %b want 1", step);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        if (step !== 1'b0 || busy !== 1'b0)
            $display("FAIL mid_rst got %b/%b want 0/0", step, busy);
        else n_pass++;
        if (position !== 32'd0 || steps_left !== 32'd0)
            $display("FAIL mid_rst_pos got %h/%0d want 0/0",
                     position, steps_left);
        else n_pass++;
        exp_pos = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if (bus.cmd_ready !== 1'b1)
            $display("FAIL mid_ready got %b want 1", bus.cmd_ready);
        else n_pass++;
        exp_rise = '{2, 8};
        exp_pos  = exp_pos + 32'd2;
        send_cmd(32'd2, 32'd6, 1'b1, 1'b0);
        watch(200, -1);
        while (exp_rise.size() > 0) begin
            int e = exp_rise.pop_front();
            g = got_rise.size() > 0 ? got_rise.pop_front() : -1;
            n_chk++;
            if (g !== e)
                $display("FAIL mid_rise got %0d want %0d", g, e);
            else n_pass++;
        end
        n_chk += 2;
        if (done_off !== 14)
            $display("FAIL mid_done got %0d want 14", done_off);
        else n_pass++;
        if (position !== exp_pos)
            $display("FAIL mid_pos got %h want %h", position, exp_pos);
        else n_pass++;
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_steps  = '0;
        bus.cmd_period = '0;
        bus.cmd_dir    = 1'b0;
        test_reset();
        test_basic();
        test_clamp();
        test_zero();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
